// File: rtl/maze_pkg.sv
// maze_pkg: shared move codes, FSM state type and coordinate stepping helpers
// for the maze path recorder.
package maze_pkg;

    // Move codes produced by the maze solver.
    localparam logic [1:0] MV_LEFT  = 2'b00;  // y - 1
    localparam logic [1:0] MV_UP    = 2'b01;  // x - 1
    localparam logic [1:0] MV_RIGHT = 2'b10;  // y + 1
    localparam logic [1:0] MV_DOWN  = 2'b11;  // x + 1

    // Helpers work on a wide coordinate; callers keep the low CW bits, which
    // gives modulo-2^CW arithmetic for any CW up to COORD_W.
    localparam int COORD_W = 16;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pos_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECORD = 3'd1,
        ST_READY  = 3'd2,
        ST_REPLAY = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // One step of the rat from (x, y) in direction mv.
    function automatic pos_t next_pos(input coord_t x, input coord_t y, input logic [1:0] mv);
        pos_t p;
        p.x = x;
        p.y = y;
        case (mv)
            MV_LEFT:  p.y = y - coord_t'(1);
            MV_UP:    p.x = x - coord_t'(1);
            MV_RIGHT: p.y = y + coord_t'(1);
            MV_DOWN:  p.x = x + coord_t'(1);
        endcase
        return p;
    endfunction

    // True when a step from (x, y) stays inside a 2^cw x 2^cw maze.
    function automatic logic in_bounds(input coord_t x, input coord_t y, input logic [1:0] mv,
                                       input int cw);
        coord_t max_c;
        logic   ok;
        max_c = coord_t'((1 << cw) - 1);
        ok    = 1'b1;
        case (mv)
            MV_LEFT:  ok = (y != '0);
            MV_UP:    ok = (x != '0);
            MV_RIGHT: ok = (y != max_c);
            MV_DOWN:  ok = (x != max_c);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/maze_path_recorder_path_buffer.sv
// path_buffer: DEPTH x 2-bit move store with a synchronous write port and a
// registered read port (read data appears the cycle after the address).
module path_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data
);

    logic [1:0] mem [DEPTH];

    // Write port: store one move per enabled cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered, sampled every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 2'b00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/maze_path_recorder.sv
// maze_path_recorder: records the solver's move stream while tracking the
// rat's cell, then replays the path as absolute (x, y) beats.
// Optional feature macro: PATH_BOUNDS_CHECK_EN (reject moves leaving the maze;
// without it coordinates wrap modulo 2^CW).
//
// Output handshake: a beat (x_out, y_out, last) transfers on a rising edge
// where out_valid && out_ready. While out_valid && !out_ready the beat is held
// unchanged. out_valid only drops after the last beat transfers, or on start/rst.
module maze_path_recorder
    import maze_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CW    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mv_valid,
    input  logic [1:0]             move,
    input  logic                   done,
    input  logic                   fail,
    input  logic                   replay,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [CW-1:0]          x_out,
    output logic [CW-1:0]          y_out,
    output logic                   last,
    output logic [$clog2(DEPTH):0] path_len,
    output logic [CW-1:0]          cur_x,
    output logic [CW-1:0]          cur_y,
    output logic                   ready_o,
    output logic                   err,
    output logic [2:0]             state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t         state;
    state_t         state_next;
    logic [LW-1:0]  idx;        // index of the beat currently presented
    logic [1:0]     rd_data;    // move idx, read ahead of the beat step
    logic [AW-1:0]  rd_addr;
    logic           full;
    logic           oob;
    logic           rec_en;
    logic           err_set;
    logic           replay_go;
    logic           beat_acc;
    pos_t           cur_step;
    pos_t           out_step;
    logic           unused_bits;

    assign full     = (path_len == LW'(DEPTH));
    assign beat_acc = out_valid && out_ready;
    assign last     = out_valid && (idx == path_len);
    assign cur_step = next_pos(coord_t'(cur_x), coord_t'(cur_y), move);
    assign out_step = next_pos(coord_t'(x_out), coord_t'(y_out), rd_data);
    assign ready_o  = (state == ST_READY);
    assign state_dbg = state;
    // Upper bits of the wide helper results are intentionally discarded.
    assign unused_bits = ^{cur_step, out_step};

`ifdef PATH_BOUNDS_CHECK_EN
    assign oob = !in_bounds(coord_t'(cur_x), coord_t'(cur_y), move, CW);
`else
    assign oob = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; start overrides every state.
    always_comb begin
        state_next = state;
        rec_en     = 1'b0;
        err_set    = 1'b0;
        replay_go  = 1'b0;
        if (start) begin
            state_next = ST_RECORD;
        end else begin
            case (state)
                ST_RECORD: begin
                    if (mv_valid && (full || oob)) begin
                        err_set    = 1'b1;
                        state_next = ST_ERROR;
                    end else begin
                        rec_en = mv_valid;
                        if (fail) begin
                            err_set    = 1'b1;
                            state_next = ST_ERROR;
                        end else if (done) begin
                            state_next = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (replay) begin
                        replay_go  = 1'b1;
                        state_next = ST_REPLAY;
                    end
                end
                ST_REPLAY: begin
                    if (beat_acc && last) begin
                        state_next = ST_READY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-ahead address: fetch the move for the beat that will be shown next.
    always_comb begin
        rd_addr = idx[AW-1:0];
        if (replay_go) begin
            rd_addr = '0;
        end else if (state == ST_REPLAY && beat_acc) begin
            rd_addr = idx[AW-1:0] + AW'(1);
        end
    end

    // Recording datapath: path length, tracked position and sticky error.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            path_len <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            err      <= 1'b0;
        end else begin
            if (rec_en) begin
                path_len <= path_len + LW'(1);
                cur_x    <= cur_step.x[CW-1:0];
                cur_y    <= cur_step.y[CW-1:0];
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Replay stepper: beat 0 is the origin, each accepted beat applies one move.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            idx       <= '0;
        end else if (replay_go) begin
            out_valid <= 1'b1;
            x_out     <= '0;
            y_out     <= '0;
            idx       <= '0;
        end else if (state == ST_REPLAY && beat_acc) begin
            if (last) begin
                out_valid <= 1'b0;
            end else begin
                idx   <= idx + LW'(1);
                x_out <= out_step.x[CW-1:0];
                y_out <= out_step.y[CW-1:0];
            end
        end
    end

    path_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_path_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rec_en),
        .wr_addr (path_len[AW-1:0]),
        .wr_data (move),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_maze_path_recorder.sv
// tb_maze_path_recorder: randomized and directed stimulus for the path
// recorder, checked against a cell-walk model through an expected-beat queue.
module tb_maze_path_recorder;
    import maze_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int SIZE  = 1 << CW;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int BW    = 2 * CW + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mv_valid;
    logic [1:0]    move;
    logic          done;
    logic          fail;
    logic          replay;
    logic          out_ready;
    logic          out_valid;
    logic [CW-1:0] x_out;
    logic [CW-1:0] y_out;
    logic          last;
    logic [LW-1:0] path_len;
    logic [CW-1:0] cur_x;
    logic [CW-1:0] cur_y;
    logic          ready_o;
    logic          err;
    logic [2:0]    state_dbg;

    int n_tests  = 0;
    int n_fail   = 0;
    int rdy_mode = 0;

    logic [BW-1:0] exp_q[$];
    logic [1:0]    path_q[$];
    int            mdl_x;
    int            mdl_y;

    maze_path_recorder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mv_valid  (mv_valid),
        .move      (move),
        .done      (done),
        .fail      (fail),
        .replay    (replay),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .x_out     (x_out),
        .y_out     (y_out),
        .last      (last),
        .path_len  (path_len),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .ready_o   (ready_o),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock and reset-free clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a cell walk on a 2^CW torus (or bounded grid).
    function automatic int dx_of(input logic [1:0] m);
        if (m == MV_UP) return -1;
        if (m == MV_DOWN) return 1;
        return 0;
    endfunction

    function automatic int dy_of(input logic [1:0] m);
        if (m == MV_LEFT) return -1;
        if (m == MV_RIGHT) return 1;
        return 0;
    endfunction

    function automatic bit legal(input int x, input int y, input logic [1:0] m);
        int nx = x + dx_of(m);
        int ny = y + dy_of(m);
        return (nx >= 0) && (nx < SIZE) && (ny >= 0) && (ny < SIZE);
    endfunction

    task automatic walk(inout int x, inout int y, input logic [1:0] m);
        x = (x + dx_of(m) + SIZE) % SIZE;
        y = (y + dy_of(m) + SIZE) % SIZE;
    endtask

    // Random path that the DUT must accept without error.
    task automatic gen_path(input int len);
        int x = 0;
        int y = 0;
        logic [1:0] m;
        path_q.delete();
        for (int i = 0; i < len; i++) begin
            m = 2'($urandom_range(0, 3));
`ifdef PATH_BOUNDS_CHECK_EN
            while (!legal(x, y, m)) m = 2'($urandom_range(0, 3));
`endif
            path_q.push_back(m);
            walk(x, y, m);
        end
    endtask

    // Output driver: always ready, toggling, or random back-pressure.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops an expected beat for every transfer, checks stall stability.
    initial begin
        logic [BW-1:0] held;
        logic [BW-1:0] e;
        bit            hold_valid;
        hold_valid = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (hold_valid) check("stall_hold", 32'({x_out, y_out, last}), 32'(held));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'({x_out, y_out, last}), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 32'({x_out, y_out, last}), 32'(e));
                    end
                    hold_valid = 1'b0;
                end else begin
                    hold_valid = 1'b1;
                    held       = {x_out, y_out, last};
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic start_rec;
        start = 1'b1;
        tick;
        start = 1'b0;
        mdl_x = 0;
        mdl_y = 0;
        check("start_len", 32'(path_len), 0);
        check("start_state", 32'(state_dbg), 32'(ST_RECORD));
        check("start_err", 32'(err), 0);
    endtask

    task automatic feed_moves(input bit gaps, input bit done_last);
        for (int i = 0; i < path_q.size(); i++) begin
            mv_valid = 1'b1;
            move     = path_q[i];
            if (done_last && i == path_q.size() - 1) done = 1'b1;
            tick;
            mv_valid = 1'b0;
            done     = 1'b0;
            walk(mdl_x, mdl_y, path_q[i]);
            if (gaps && $urandom_range(0, 3) == 0) tick;
        end
        if (!(done_last && path_q.size() > 0)) begin
            done = 1'b1;
            tick;
            done = 1'b0;
        end
        check("rec_len", 32'(path_len), 32'(path_q.size()));
        check("rec_cur_x", 32'(cur_x), 32'(mdl_x));
        check("rec_cur_y", 32'(cur_y), 32'(mdl_y));
        check("rec_ready", 32'(ready_o), 1);
    endtask

    task automatic push_expected;
        int x = 0;
        int y = 0;
        int n = path_q.size();
        for (int k = 0; k <= n; k++) begin
            exp_q.push_back({CW'(x), CW'(y), (k == n)});
            if (k < n) walk(x, y, path_q[k]);
        end
    endtask

    task automatic do_replay(input int mode);
        push_expected();
        rdy_mode = mode;
        replay   = 1'b1;
        tick;
        replay = 1'b0;
        check("valid_rise", 32'(out_valid), 1);
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            if (mode == 2 && $urandom_range(0, 7) == 0) replay = 1'b1;
            tick;
            replay = 1'b0;
        end
        if (exp_q.size() != 0) begin
            check("replay_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        check("valid_drop", 32'(out_valid), 0);
        check("ready_after", 32'(ready_o), 1);
        rdy_mode = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mv_valid = 1'b0; move = 2'b00;
        done = 1'b0; fail = 1'b0; replay = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_len", 32'(path_len), 0);
        check("rst_pos", 32'({cur_x, cur_y}), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ready", 32'(ready_o), 0);
        check("rst_last", 32'(last), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // Right, right, down: beats (0,0) (0,1) (0,2) (1,2).
        path_q.delete();
        path_q.push_back(MV_RIGHT); path_q.push_back(MV_RIGHT); path_q.push_back(MV_DOWN);
        start_rec();
        feed_moves(1'b0, 1'b0);
        check("dir_len", 32'(path_len), 3);
        check("dir_cur", 32'({cur_x, cur_y}), 32'({4'd1, 4'd2}));
        do_replay(0);
        do_replay(1);
        do_replay(1);

        // Moves in READY are ignored.
        mv_valid = 1'b1; move = MV_DOWN;
        tick;
        mv_valid = 1'b0;
        check("ready_mv_len", 32'(path_len), 3);
        check("ready_mv_cur", 32'({cur_x, cur_y}), 32'({4'd1, 4'd2}));

        // Done with no moves: one beat (0,0) with last.
        path_q.delete();
        start_rec();
        feed_moves(1'b0, 1'b0);
        do_replay(0);

        // Overflow: DEPTH moves then one more.
        path_q.delete();
        for (int i = 0; i < DEPTH; i++) path_q.push_back((i % 2 == 0) ? MV_RIGHT : MV_LEFT);
        start_rec();
        for (int i = 0; i < DEPTH; i++) begin
            mv_valid = 1'b1; move = path_q[i];
            tick;
            walk(mdl_x, mdl_y, path_q[i]);
        end
        move = MV_RIGHT;
        tick;
        mv_valid = 1'b0;
        check("ovf_err", 32'(err), 1);
        check("ovf_state", 32'(state_dbg), 32'(ST_ERROR));
        check("ovf_len", 32'(path_len), DEPTH);
        check("ovf_cur", 32'({cur_x, cur_y}), 32'({CW'(mdl_x), CW'(mdl_y)}));
        replay = 1'b1;
        tick;
        replay = 1'b0;
        check("err_no_replay", 32'(out_valid), 0);
        check("err_hold", 32'(state_dbg), 32'(ST_ERROR));

        // Left at the origin.
        start_rec();
        mv_valid = 1'b1; move = MV_LEFT;
        tick;
        mv_valid = 1'b0;
        tick;
`ifdef PATH_BOUNDS_CHECK_EN
        check("oob_err", 32'(err), 1);
        check("oob_state", 32'(state_dbg), 32'(ST_ERROR));
        check("oob_len", 32'(path_len), 0);
        check("oob_cur", 32'({cur_x, cur_y}), 0);
`else
        check("wrap_cur_y", 32'(cur_y), 15);
        check("wrap_cur_x", 32'(cur_x), 0);
        check("wrap_len", 32'(path_len), 1);
        check("wrap_err", 32'(err), 0);
`endif

        // start during replay aborts the stream.
        path_q.delete();
        path_q.push_back(MV_RIGHT); path_q.push_back(MV_DOWN); path_q.push_back(MV_RIGHT);
        path_q.push_back(MV_DOWN); path_q.push_back(MV_RIGHT);
        start_rec();
        feed_moves(1'b0, 1'b1);
        push_expected();
        rdy_mode = 0;
        replay = 1'b1;
        tick;
        replay = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        exp_q.delete();
        check("abort_valid", 32'(out_valid), 0);
        check("abort_len", 32'(path_len), 0);
        check("abort_state", 32'(state_dbg), 32'(ST_RECORD));
        fail = 1'b1;
        tick;
        fail = 1'b0;
        check("fail_err", 32'(err), 1);
        check("fail_state", 32'(state_dbg), 32'(ST_ERROR));

        // fail wins over done in the same cycle.
        start_rec();
        fail = 1'b1; done = 1'b1;
        tick;
        fail = 1'b0; done = 1'b0;
        check("fail_prio_state", 32'(state_dbg), 32'(ST_ERROR));
        check("fail_prio_err", 32'(err), 1);

        // Reset mid-recording.
        gen_path(2);
        start_rec();
        mv_valid = 1'b1; move = path_q[0];
        tick;
        mv_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("midrst_len", 32'(path_len), 0);
        check("midrst_pos", 32'({cur_x, cur_y}), 0);

        // Randomized paths, gaps and back-pressure.
        for (int it = 0; it < 20; it++) begin
            gen_path($urandom_range(0, DEPTH));
            start_rec();
            feed_moves(1'b1, 1'($urandom_range(0, 1)));
            do_replay($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) do_replay(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
